// File: rtl/accumulator_pkg.sv
// rtl/accumulator_pkg.sv - shared widths, LFSR constants and FSM states for the accumulator load generator
package accumulator_pkg;

  localparam int          ACC_DATA_WIDTH = 32;
  localparam logic [15:0] LFSR_MASK      = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED   = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Galois step: shift right, fold the mask back in when a one falls out
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

endpackage

// File: rtl/lfsr16_galois.sv
// rtl/lfsr16_galois.sv - 16-bit Galois LFSR with seed-load and advance enables
module lfsr16_galois
  import accumulator_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  output logic [15:0] value
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= SEED;
    end else if (load) begin
      value <= SEED;
    end else if (advance) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/accumulator_load_gen.sv
// rtl/accumulator_load_gen.sv - pseudo-random load source with golden running sum; LOADGEN_CHECK_EN adds the result checker
module accumulator_load_gen
  import accumulator_pkg::*;
#(
  parameter int          NUM_LOADS   = 1024,
  parameter int          DATA_WIDTH  = ACC_DATA_WIDTH,
  parameter int          LOAD_BITS   = 16,
  parameter logic [15:0] SEED        = DEFAULT_SEED,
  parameter int          CHECK_DELAY = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  load_ready,
  output logic                  load_valid,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] golden_sum,
  input  logic [DATA_WIDTH-1:0] result_in,
  output logic                  check_fail
);

  // An all-zero seed would lock the LFSR, so it is promoted to 1
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam int CNT_W = (NUM_LOADS > 1) ? $clog2(NUM_LOADS) : 1;
  localparam int DLY_W = (CHECK_DELAY > 1) ? $clog2(CHECK_DELAY) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_LOADS - 1);
  localparam logic [DLY_W-1:0] LAST_DLY = DLY_W'(CHECK_DELAY - 1);

  state_e           state;
  logic [CNT_W-1:0] count;
  logic [DLY_W-1:0] dly_cnt;
  logic [15:0]      lfsr;
  logic             launch;
  logic             xfer;
  logic             check_end;

  assign launch    = start && ((state == IDLE) || (state == DONE));
  assign xfer      = load_valid && load_ready;
  assign check_end = (state == CHECK) && (dly_cnt == LAST_DLY);

  lfsr16_galois #(
    .SEED(SEED_EFF)
  ) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .load   (launch),
    .advance(xfer),
    .value  (lfsr)
  );

  assign load_data = load_valid ? DATA_WIDTH'(lfsr[LOAD_BITS-1:0]) : '0;
  assign busy      = (state == RUN) || (state == CHECK);
  assign done      = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      dly_cnt    <= '0;
      load_valid <= 1'b0;
      golden_sum <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RUN;
            count      <= '0;
            golden_sum <= '0;
            load_valid <= 1'b1;
          end
        end
        RUN: begin
          if (xfer) begin
            golden_sum <= golden_sum + load_data;
            count      <= count + 1'b1;
            if (count == LAST_CNT) begin
              state      <= CHECK;
              load_valid <= 1'b0;
              dly_cnt    <= '0;
            end
          end
        end
        CHECK: begin
          if (check_end) begin
            state <= DONE;
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LOADGEN_CHECK_EN
  // Sampled once, on the last CHECK cycle; sticky until the next run begins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      check_fail <= 1'b0;
    end else if (launch) begin
      check_fail <= 1'b0;
    end else if (check_end && (result_in != golden_sum)) begin
      check_fail <= 1'b1;
    end
  end
`else
  logic unused_result;
  assign unused_result = ^result_in;
  assign check_fail    = 1'b0;
`endif

endmodule

// File: tb/tb_accumulator_load_gen.sv
// tb/tb_accumulator_load_gen.sv - directed scoreboard bench for accumulator_load_gen
`timescale 1ns/1ps
module tb_accumulator_load_gen;

  localparam int S_DELAY = 4;
`ifdef LOADGEN_CHECK_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  logic clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  logic        reset;
  logic        s_start, s_ready, s_valid, s_busy, s_done, s_fail;
  logic [31:0] s_data, s_sum, s_result;
  logic        b_start, b_ready, b_valid, b_busy, b_done, b_fail;
  logic [31:0] b_data, b_sum, b_result;

  accumulator_load_gen #(
    .NUM_LOADS  (3),
    .CHECK_DELAY(S_DELAY)
  ) dut_small (
    .clk       (clk_tb),
    .reset     (reset),
    .start     (s_start),
    .load_ready(s_ready),
    .load_valid(s_valid),
    .load_data (s_data),
    .busy      (s_busy),
    .done      (s_done),
    .golden_sum(s_sum),
    .result_in (s_result),
    .check_fail(s_fail)
  );

  accumulator_load_gen dut_big (
    .clk       (clk_tb),
    .reset     (reset),
    .start     (b_start),
    .load_ready(b_ready),
    .load_valid(b_valid),
    .load_data (b_data),
    .busy      (b_busy),
    .done      (b_done),
    .golden_sum(b_sum),
    .result_in (b_result),
    .check_fail(b_fail)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp_sum;
  logic [31:0] run_sum;
  int          n_xfer;
  int          first_v, last_v, done_at, n_valid;
  logic [15:0] m;
  logic [31:0] msum;

  function automatic logic [15:0] m_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_model(input int n);
    logic [15:0] v;
    v = 16'hACE1;
    sb_q.delete();
    exp_sum = 32'd0;
    run_sum = 32'd0;
    n_xfer  = 0;
    for (int i = 0; i < n; i++) begin
      sb_q.push_back({16'h0000, v});
      run_sum += {16'h0000, v};
      v = m_next(v);
    end
  endtask

  // Sample the small DUT at the falling edge; a pending handshake pops the scoreboard
  task automatic sample();
    logic [31:0] e;
    @(negedge clk_tb);
    if (s_valid && s_ready) begin
      chk("sum_before_xfer", s_sum, exp_sum);
      chk("sb_queue_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("load_data", s_data, e);
        exp_sum += e;
      end
      n_xfer++;
    end
  endtask

  task automatic adv();
    @(posedge clk_tb);
    #1;
  endtask

  task automatic run_to_done(input string tag);
    first_v = -1; last_v = -1; done_at = -1; n_valid = 0;
    for (int k = 1; k <= 60; k++) begin
      sample();
      if (s_valid) begin
        if (first_v < 0) first_v = k;
        last_v = k;
        n_valid++;
      end
      if (s_done) begin
        done_at = k;
        break;
      end
      adv();
    end
    chk({tag, "_done_reached"}, 32'(done_at >= 0), 32'd1);
  endtask

  initial begin
    reset = 1'b1; s_start = 1'b0; s_ready = 1'b0; b_start = 1'b0; b_ready = 1'b0;
    s_result = 32'd0; b_result = 32'd0; exp_sum = 32'd0; run_sum = 32'd0; n_xfer = 0;

    // start held while reset is high must have no effect
    adv(); s_start = 1'b1;
    adv(); adv();
    sample();
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_data", s_data, 32'd0);
    chk("rst_busy", 32'(s_busy), 32'd0);
    chk("rst_done", 32'(s_done), 32'd0);
    chk("rst_sum", s_sum, 32'd0);
    chk("rst_fail", 32'(s_fail), 32'd0);
    adv(); s_start = 1'b0; reset = 1'b0;
    sample();
    chk("start_under_reset_busy", 32'(s_busy), 32'd0);

    // run 1: literal sequence, latency, no bubbles, matching result
    sb_q = '{32'h0000ACE1, 32'h0000E270, 32'h00007138};
    exp_sum = 32'd0; n_xfer = 0;
    s_result = 32'h00020089;
    adv(); s_start = 1'b1; s_ready = 1'b1;
    sample();
    chk("valid_before_launch", 32'(s_valid), 32'd0);
    adv(); s_start = 1'b0;
    run_to_done("r1");
    chk("r1_first_valid_cycle", 32'(first_v), 32'd1);
    chk("r1_valid_cycles", 32'(n_valid), 32'd3);
    chk("r1_no_bubbles", 32'(last_v - first_v), 32'd2);
    chk("r1_done_latency", 32'(done_at - last_v), 32'(S_DELAY + 1));
    chk("r1_xfers", 32'(n_xfer), 32'd3);
    chk("r1_queue_empty", 32'(sb_q.size()), 32'd0);
    chk("r1_golden_sum", s_sum, 32'h00020089);
    chk("r1_busy_in_done", 32'(s_busy), 32'd0);
    chk("r1_check_fail", 32'(s_fail), 32'd0);

    // run 2: replay from DONE, stall mid-run, stray start, mismatching result
    push_model(3);
    s_result = run_sum + 32'd1;
    adv(); s_start = 1'b1;
    sample();
    chk("r2_sum_held_in_done", s_sum, 32'h00020089);
    adv(); s_start = 1'b0;
    sample();
    chk("r2_replay_first", s_data, 32'h0000ACE1);
    chk("r2_replay_sum_cleared", s_sum, 32'd0);
    chk("r2_done_cleared", 32'(s_done), 32'd0);
    adv(); s_ready = 1'b0; s_start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sample();
      chk("stall_valid", 32'(s_valid), 32'd1);
      chk("stall_data", s_data, sb_q[0]);
      chk("stall_sum", s_sum, exp_sum);
      adv(); s_start = 1'b0;
    end
    s_ready = 1'b1;
    run_to_done("r2");
    chk("r2_xfers", 32'(n_xfer), 32'd3);
    chk("r2_queue_empty", 32'(sb_q.size()), 32'd0);
    chk("r2_golden_sum", s_sum, run_sum);
    chk("r2_check_fail", 32'(s_fail), 32'(CHK_EN));
    for (int k = 0; k < 3; k++) begin
      adv(); sample();
      chk("r2_fail_sticky", 32'(s_fail), 32'(CHK_EN));
      chk("r2_done_held", 32'(s_done), 32'd1);
    end
    adv(); s_start = 1'b1; s_ready = 1'b0;
    sample();
    adv(); s_start = 1'b0;
    sample();
    chk("r3_fail_cleared", 32'(s_fail), 32'd0);
    chk("r3_busy", 32'(s_busy), 32'd1);

    // big run: reset while the 500th value is on the bus
    adv(); b_start = 1'b1; b_ready = 1'b1;
    adv(); b_start = 1'b0;
    m = 16'hACE1; msum = 32'd0;
    for (int i = 0; i < 499; i++) begin
      msum += {16'h0000, m};
      m = m_next(m);
      adv();
    end
    chk("big_data_500", b_data, {16'h0000, m});
    chk("big_sum_499", b_sum, msum);
    chk("big_busy", 32'(b_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(b_valid), 32'd0);
    chk("async_rst_data", b_data, 32'd0);
    chk("async_rst_sum", b_sum, 32'd0);
    chk("async_rst_busy", 32'(b_busy), 32'd0);
    chk("async_rst_done", 32'(b_done), 32'd0);
    chk("async_rst_fail", 32'(b_fail), 32'd0);
    chk("async_rst_small_busy", 32'(s_busy), 32'd0);
    adv(); reset = 1'b0; b_start = 1'b1;
    adv(); b_start = 1'b0;
    #3;
    chk("big_restart_data", b_data, 32'h0000ACE1);
    chk("big_restart_sum", b_sum, 32'd0);
    chk("big_restart_valid", 32'(b_valid), 32'd1);
    b_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
